// File: rtl/data_cache_responder.sv
`timescale 1ns/1ps
// Direct-mapped, write-through, no-write-allocate data cache between the core's
// load/store port and a word-addressed backing memory, with saturating hit/miss counters.
module data_cache_responder #(
  parameter int LINES = 16,
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] address,
  input  logic [31:0] data,
  input  logic        r_en,
  input  logic        w_en,
  output logic        stall,
  output logic [31:0] saida_cache,
  output logic [11:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic        mem_r_en,
  output logic        mem_w_en,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] hits,
  output logic [15:0] misses
);

  localparam int TAG_W = 12 - IDX_W;

  typedef enum logic [1:0] {IDLE, MISS_RD, WR_THRU, DONE} state_t;

  state_t             state_r;
  logic [LINES-1:0]   valid_r;
  logic [TAG_W-1:0]   tag_r  [LINES];
  logic [31:0]        word_r [LINES];

  logic               req_s;
  logic               hit_s;
  logic               txn_hit_s;
  logic [IDX_W-1:0]   req_idx_s;
  logic [TAG_W-1:0]   req_tag_s;
  logic [IDX_W-1:0]   txn_idx_s;
  logic [TAG_W-1:0]   txn_tag_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Tag compares for the incoming request and for the in-flight (latched) transaction
  always_comb begin
    req_s     = r_en | w_en;
    req_idx_s = address[IDX_W-1:0];
    req_tag_s = address[11:IDX_W];
    txn_idx_s = mem_address[IDX_W-1:0];
    txn_tag_s = mem_address[11:IDX_W];
    hit_s     = valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s);
    txn_hit_s = valid_r[txn_idx_s] && (tag_r[txn_idx_s] == txn_tag_s);
    stall     = req_s && (state_r != DONE);
  end

  // Request FSM, line storage, backing-memory port and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      valid_r     <= '0;
      saida_cache <= 32'd0;
      hits        <= 16'd0;
      misses      <= 16'd0;
      mem_address <= 12'd0;
      mem_wdata   <= 32'd0;
      mem_r_en    <= 1'b0;
      mem_w_en    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            if (w_en) begin
              mem_w_en    <= 1'b1;
              mem_address <= address;
              mem_wdata   <= data;
              state_r     <= WR_THRU;
            end else if (hit_s) begin
              saida_cache <= word_r[req_idx_s];
              hits        <= sat_inc(hits);
              state_r     <= DONE;
            end else begin
              misses      <= sat_inc(misses);
              mem_r_en    <= 1'b1;
              mem_address <= address;
              state_r     <= MISS_RD;
            end
          end
        end
        // The transaction address is latched, so the core dropping req mid-flight is harmless
        MISS_RD: begin
          if (mem_ready) begin
            valid_r[txn_idx_s] <= 1'b1;
            tag_r[txn_idx_s]   <= txn_tag_s;
            word_r[txn_idx_s]  <= mem_rdata;
            saida_cache        <= mem_rdata;
            mem_r_en           <= 1'b0;
            mem_address        <= 12'd0;
            state_r            <= DONE;
          end
        end
        WR_THRU: begin
          if (mem_ready) begin
            if (txn_hit_s) begin
              word_r[txn_idx_s] <= mem_wdata;
            end
            mem_w_en    <= 1'b0;
            mem_address <= 12'd0;
            mem_wdata   <= 32'd0;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (!req_s) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache_responder.sv
`timescale 1ns/1ps
// Bench for data_cache_responder: directed vector table from the test plan, multi-cycle
// corner sequences, then randomized traffic against a line-level reference model.
module tb_data_cache_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] address;
  logic [31:0] data;
  logic        r_en, w_en;
  logic        stall;
  logic [31:0] saida_cache;
  logic [11:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_r_en, mem_w_en;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] hits, misses;

  data_cache_responder dut (
    .clk(clk), .reset(reset), .address(address), .data(data), .r_en(r_en), .w_en(w_en),
    .stall(stall), .saida_cache(saida_cache), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hits(hits), .misses(misses)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  bit [31:0] mem_arr [4096];
  int        mem_lat = 1;
  bit        spur_en = 1'b0;

  // Reference cache model
  bit        m_valid [16];
  bit [7:0]  m_tag   [16];
  bit [31:0] m_word  [16];
  int        m_hits, m_misses;
  bit [31:0] m_saida;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  // Backing memory: completes an active request after mem_lat cycles of mem_*_en
  initial begin
    int  cnt;
    bit  real_done;
    cnt = 0;
    real_done = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (real_done) begin
        mem_ready = 1'b0;
        real_done = 1'b0;
        cnt = 0;
      end else begin
        mem_ready = 1'b0;
        if (mem_r_en || mem_w_en) begin
          cnt++;
          if (cnt >= mem_lat) begin
            mem_ready = 1'b1;
            real_done = 1'b1;
            if (mem_w_en) mem_arr[mem_address] = mem_wdata;
            else mem_rdata = mem_arr[mem_address];
          end
        end else begin
          cnt = 0;
          if (spur_en && $urandom_range(0, 7) == 0) begin
            mem_ready = 1'b1;
            mem_rdata = $urandom;
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    r_en = 1'b0;
    w_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_misses = 0;
    m_saida = 32'd0;
  endtask

  task automatic do_req(input logic wr, input logic [11:0] a, input logic [31:0] d, input int lat,
                        output int sc, output logic saw_rd, output logic saw_wr,
                        output logic [31:0] wd, output logic [11:0] ma);
    mem_lat = lat;
    @(negedge clk);
    address = a;
    data = d;
    w_en = wr;
    r_en = !wr;
    sc = 0;
    saw_rd = 1'b0;
    saw_wr = 1'b0;
    wd = 32'd0;
    ma = 12'd0;
    #1;
    while (stall && sc < 64) begin
      sc++;
      @(negedge clk);
      #1;
      if (mem_r_en) begin saw_rd = 1'b1; ma = mem_address; end
      if (mem_w_en) begin saw_wr = 1'b1; ma = mem_address; wd = mem_wdata; end
    end
    r_en = 1'b0;
    w_en = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic        wr;
    logic [11:0] a;
    logic [31:0] d;
    int          lat;
    int          sc;
    logic [31:0] q;
    int          h;
    int          m;
    logic        rd_seen;
    logic        wr_seen;
  } vec_t;

  vec_t vt [8];

  initial begin
    int          sc;
    logic        srd, swr;
    logic [31:0] wd;
    logic [11:0] ma;

    reset = 1'b1;
    address = 12'd0;
    data = 32'd0;
    r_en = 1'b0;
    w_en = 1'b0;

    mem_arr[12'h005] = 32'hDEADBEEF;
    mem_arr[12'h025] = 32'hCAFEF00D;
    mem_arr[12'h035] = 32'h0BADCAFE;

    //          wr    addr     data          lat stall q             h  m  rd    wr
    vt[0] = '{1'b0, 12'h005, 32'h0,        3, 4, 32'hDEADBEEF, 0, 1, 1'b1, 1'b0};
    vt[1] = '{1'b0, 12'h005, 32'h0,        3, 1, 32'hDEADBEEF, 1, 1, 1'b0, 1'b0};
    vt[2] = '{1'b1, 12'h005, 32'h12345678, 2, 3, 32'hDEADBEEF, 1, 1, 1'b0, 1'b1};
    vt[3] = '{1'b0, 12'h005, 32'h0,        2, 1, 32'h12345678, 2, 1, 1'b0, 1'b0};
    vt[4] = '{1'b1, 12'h015, 32'hAAAA5555, 1, 2, 32'h12345678, 2, 1, 1'b0, 1'b1};
    vt[5] = '{1'b0, 12'h005, 32'h0,        1, 1, 32'h12345678, 3, 1, 1'b0, 1'b0};
    vt[6] = '{1'b0, 12'h025, 32'h0,        2, 3, 32'hCAFEF00D, 3, 2, 1'b1, 1'b0};
    vt[7] = '{1'b0, 12'h005, 32'h0,        1, 2, 32'h12345678, 3, 3, 1'b1, 1'b0};

    do_reset();
    #1;
    chk("reset_hits", 32'(hits), 32'd0);
    chk("reset_misses", 32'(misses), 32'd0);
    chk("reset_saida", saida_cache, 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_mem_en", {30'd0, mem_r_en, mem_w_en}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      do_req(vt[i].wr, vt[i].a, vt[i].d, vt[i].lat, sc, srd, swr, wd, ma);
      chk($sformatf("v%0d_stall", i), 32'(sc), 32'(vt[i].sc));
      chk($sformatf("v%0d_saida", i), saida_cache, vt[i].q);
      chk($sformatf("v%0d_hits", i), 32'(hits), 32'(vt[i].h));
      chk($sformatf("v%0d_misses", i), 32'(misses), 32'(vt[i].m));
      chk($sformatf("v%0d_mem_r_en", i), 32'(srd), 32'(vt[i].rd_seen));
      chk($sformatf("v%0d_mem_w_en", i), 32'(swr), 32'(vt[i].wr_seen));
      if (vt[i].wr) begin
        chk($sformatf("v%0d_wdata", i), wd, vt[i].d);
        chk($sformatf("v%0d_waddr", i), 32'(ma), 32'(vt[i].a));
      end
    end
    chk("mem_015_written", mem_arr[12'h015], 32'hAAAA5555);

    // Reset during MISS_RD aborts the fill
    mem_lat = 5;
    @(negedge clk);
    address = 12'h005;
    r_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_stall_eq_req", 32'(stall), 32'd1);
    chk("abort_hits", 32'(hits), 32'd0);
    chk("abort_misses", 32'(misses), 32'd0);
    chk("abort_saida", saida_cache, 32'd0);
    r_en = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_mem_r_en", 32'(mem_r_en), 32'd0);
    repeat (6) @(negedge clk);
    do_req(1'b0, 12'h005, 32'h0, 1, sc, srd, swr, wd, ma);
    chk("post_abort_stall", 32'(sc), 32'd2);
    chk("post_abort_misses", 32'(misses), 32'd1);
    chk("post_abort_saida", saida_cache, 32'h12345678);

    // req dropped mid-miss: the fill still completes
    mem_lat = 4;
    @(negedge clk);
    address = 12'h035;
    r_en = 1'b1;
    @(negedge clk);
    r_en = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk("drop_mem_r_en", 32'(mem_r_en), 32'd0);
    chk("drop_misses", 32'(misses), 32'd2);
    chk("drop_saida", saida_cache, 32'h0BADCAFE);
    do_req(1'b0, 12'h035, 32'h0, 1, sc, srd, swr, wd, ma);
    chk("drop_then_hit_stall", 32'(sc), 32'd1);
    chk("drop_then_hit_hits", 32'(hits), 32'd1);

    // Randomized traffic vs. reference model, spurious mem_ready pulses while idle
    for (int i = 0; i < 64; i++) mem_arr[i] = $urandom;
    do_reset();
    spur_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic [11:0] a;
      logic [31:0] d;
      logic        wr;
      int          lat, exp_sc;
      logic [3:0]  idx;
      logic [7:0]  tg;
      bit          hit;
      logic [31:0] exp_q;
      a   = 12'(($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
      d   = $urandom;
      wr  = ($urandom_range(0, 9) < 3);
      lat = $urandom_range(1, 4);
      idx = a[3:0];
      tg  = a[11:4];
      hit = m_valid[idx] && (m_tag[idx] == tg);
      if (wr) begin
        exp_sc = lat + 1;
        if (hit) m_word[idx] = d;
        exp_q = m_saida;
      end else if (hit) begin
        exp_sc = 1;
        exp_q = m_word[idx];
        if (m_hits < 65535) m_hits++;
      end else begin
        exp_sc = lat + 1;
        exp_q = mem_arr[a];
        if (m_misses < 65535) m_misses++;
        m_valid[idx] = 1'b1;
        m_tag[idx] = tg;
        m_word[idx] = exp_q;
      end
      m_saida = exp_q;
      do_req(wr, a, d, lat, sc, srd, swr, wd, ma);
      chk($sformatf("r%0d_stall", n), 32'(sc), 32'(exp_sc));
      chk($sformatf("r%0d_saida", n), saida_cache, exp_q);
      chk($sformatf("r%0d_hits", n), 32'(hits), 32'(m_hits));
      chk($sformatf("r%0d_misses", n), 32'(misses), 32'(m_misses));
      if (wr) chk($sformatf("r%0d_mem_written", n), mem_arr[a], d);
    end
    spur_en = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/data_cache_responder.md
# data_cache_responder

Responder (memory-side) end of the processor's load/store interface: a direct-mapped, write-through, no-write-allocate data cache that answers the multicycle MIPS core's `r_en`/`w_en`/`address`/`data` requests with `saida_cache` and a `stall` handshake. It forwards misses and all writes to a word-addressed backing memory over a request/ready interface. It also keeps saturating hit/miss counters for display on the board.

## Interface
- `LINES`, 16: number of cache lines (one 32-bit word each); power of two, 2..256.
- `IDX_W`, log2(LINES) = 4: index width; tag width = 12 − IDX_W.

- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `address` in 12: word address from core, held stable while the request is active.
- `data` in 32: store data from core.
- `r_en` in 1: load request (level, held for the core's whole Memory state).
- `w_en` in 1: store request (level).
- `stall` out 1: high while the current request is unserved.
- `saida_cache` out 32: load result, registered, held until the next completed load.
- `mem_address` out 12: backing memory word address.
- `mem_wdata` out 32: backing memory write data.
- `mem_r_en` out 1: backing memory read request.
- `mem_w_en` out 1: backing memory write request.
- `mem_rdata` in 32: backing memory read data, valid when `mem_ready`=1.
- `mem_ready` in 1: backing memory completion, one-cycle pulse.
- `hits` out 16: load-hit counter, saturating.
- `misses` out 16: load-miss counter, saturating.

## Operation
- Storage: per line `valid`, `tag[11−IDX_W:0]`, `word[31:0]`. Index = `address[IDX_W−1:0]`, tag = `address[11:IDX_W]`.
- `req` = `r_en | w_en`. If both are high, treat as a store (`w_en` priority).
- States:
  - IDLE: if `req` is high, do a combinational tag compare. Load hit → `saida_cache` <= line word, `hits`++ → DONE. Load miss → MISS_RD, `misses`++. Store → WR_THRU.
  - MISS_RD: `mem_r_en`=1, `mem_address`=`address`. On `mem_ready`: write the line (valid=1, tag, word=`mem_rdata`) and set `saida_cache` <= `mem_rdata` → DONE.
  - WR_THRU: `mem_w_en`=1, `mem_address`=`address`, `mem_wdata`=`data`. On `mem_ready`: if the line is valid and the tag matches, word <= `data`; otherwise the line is unchanged (no allocate) → DONE.
  - DONE: wait until `req`=0, then → IDLE. The held request is never served twice.
- `stall` = `req` & (state != DONE). It is combinational, so it is high in the same cycle the request first appears. Every request, including a hit, gives at least one cycle of `stall`=1 followed by `stall`=0; the core requires this stall pulse.
- `mem_*` outputs are 0 outside MISS_RD/WR_THRU.
- Counters saturate at 16'hFFFF. Stores are not counted.

## Timing
- Reset (at a clock edge with `reset`=1):
  - all `valid` <= 0, state <= IDLE;
  - `saida_cache`, `hits`, `misses` <= 0;
  - `mem_r_en` = `mem_w_en` = 0 from the next cycle;
  - `stall` = `req` (state is IDLE).
- Reset during MISS_RD/WR_THRU aborts: no line update, no counter change, and a later `mem_ready` is ignored.
- Load hit: request cycle C (`stall`=1) → DONE at C+1 (`stall`=0, `saida_cache` valid).
- Load miss: `mem_r_en` is high from C+1 until the `mem_ready` cycle R inclusive. `stall` falls and data is valid at R+1. With memory latency L cycles, total stall = L+1 cycles.
- Store: same as a load miss, using `mem_w_en`. The line update is visible to a load issued at R+1 or later.
- `mem_ready` is ignored in IDLE and DONE.
- `req` deasserting while in MISS_RD/WR_THRU does not abort: the transaction completes, then the state passes through DONE to IDLE.
- Back-to-back requests: after DONE, `req` must be low for at least one cycle before the next request is accepted. The core guarantees this via Write Back/Fetch.

## Test plan
- Reset, then load `address`=12'h005 with memory returning 32'hDEADBEEF after 3 cycles → `stall` high 4 cycles, `saida_cache`=32'hDEADBEEF, `misses`=1, `hits`=0.
- Repeat the load of 12'h005 → `stall` high exactly 1 cycle, no `mem_r_en`, `saida_cache`=32'hDEADBEEF, `hits`=1.
- Store 32'h12345678 to 12'h005 (hit), then load 12'h005 → `mem_w_en` pulse with `mem_wdata`=32'h12345678; load hits and returns 32'h12345678.
- Store to 12'h015 (same index 5, different tag), then load 12'h005 → memory written; line 5 still holds tag 0, so the load hits with the old word; `misses` unchanged.
- Load 12'h025 (conflict on index 5), then load 12'h005 → both miss, `misses` +2, line replaced each time.
- Assert `reset` during MISS_RD, then load 12'h005 → no fill occurred, counters are 0, and the load misses.
